sram_arbiter: RTL
=================

Name: sram_arbiter

Overview:
- Round-robin arbiter and burst sequencer that shares the single-port On-Chip SRAM between N_REQ bus masters: requester 0 is the DMA controller, 1 is SPI, 2 is I2C.
- Grants one requester at a time and drives the SRAM port for a full burst of incrementing word accesses.
- Returns read data and per-beat strobes to the granted requester.
- Sits between the requesters and the SRAM, inside the interconnect/bridge level of the SoC.

Parameters:
- N_REQ, 3, number of requesters.
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits.
- LEN_W, 4, burst-length field width; burst has len+1 beats, so 1..16.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_i  in  N_REQ  per-requester access request.
- we_i  in  N_REQ  per-requester write (1) / read (0).
- addr_i  in  N_REQ*ADDR_W  per-requester burst start address; slice k is requester k.
- len_i  in  N_REQ*LEN_W  per-requester beats minus 1.
- wdata_i  in  N_REQ*DATA_W  per-requester write data for the current beat.
- lock_i  in  N_REQ  per-requester grant-lock request (used only with ARB_LOCK_EN).
- gnt_o  out  N_REQ  one-hot grant, held for the whole burst.
- beat_o  out  N_REQ  one-hot pulse: the current beat was issued to SRAM; write data consumed.
- rvalid_o  out  N_REQ  one-hot pulse: rdata_o is valid for that requester.
- rdata_o  out  DATA_W  read data, shared bus.
- done_o  out  N_REQ  one-hot single-cycle pulse on the last beat (write) or last rvalid (read).
- sram_en_o  out  1  SRAM access enable.
- sram_we_o  out  1  SRAM write enable.
- sram_addr_o  out  ADDR_W  SRAM address.
- sram_wdata_o  out  DATA_W  SRAM write data.
- sram_rdata_i  in  DATA_W  SRAM read data, valid 1 cycle after a read with sram_en_o=1.

Behaviour:
- Reset (reset=0, async): state=IDLE; every output 0; round-robin pointer=0 (requester 0 highest priority); beat counter 0.
- States are IDLE, BURST and DRAIN.
- IDLE:
  - If any req_i is set, pick the winner by round-robin starting at the pointer.
  - Register gnt_o, the base address, len and we; go to BURST. gnt_o rises 1 cycle after req_i is sampled.
  - req_i is sampled only in IDLE. Dropping req mid-burst has no effect.
- BURST, every cycle:
  - sram_en_o=1; sram_we_o=latched we; sram_addr_o=base+4*beat; sram_wdata_o=wdata_i slice of the grantee; beat_o[g]=1.
  - Address arithmetic is modulo 2^ADDR_W, so it wraps from 0xFFFFFFFC to 0x00000000. Low 2 address bits pass through unchanged.
  - Beat counter increments each cycle.
  - On beat==len for a write: done_o[g]=1 in the same cycle; then go to IDLE.
  - On beat==len for a read: go to DRAIN.
- Reads: rvalid_o[g]=1 and rdata_o=sram_rdata_i one cycle after each read beat.
- DRAIN:
  - Final rvalid_o[g] and done_o[g] are asserted together; then go to IDLE.
- On leaving a burst:
  - gnt_o clears.
  - The pointer becomes (g+1) mod N_REQ.
  - One IDLE turnaround cycle always follows before the next grant.
- Simultaneous requests: the pointer decides. At reset, with all requesting, the order is 0,1,2,0…
- len=0 gives a single beat. The maximum is 16 beats.
- Reset mid-burst: the burst is aborted, all outputs clear immediately, and no done_o is issued.
- The outputs gnt_o, beat_o, rvalid_o and done_o are each at most one-hot.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined: if the grantee has lock_i[g]=1 and req_i[g]=1 on its final beat, it is re-granted with no IDLE turnaround. A new base, len and we are latched from its inputs in the done cycle, and the pointer is not advanced. A write burst then continues directly in BURST; a read burst goes through DRAIN with the next burst's first beat overlapping it.
- Undefined: lock_i is ignored and the behaviour is as above.

Decomposition:
- Package sram_arb_pkg holds:
  - the state enum (IDLE, BURST, DRAIN);
  - the constants for the word increment (4) and the default widths.
- One sub-module, rr_picker: combinational round-robin selector. Inputs are the request vector and the pointer; output is the one-hot winner and its index.

Test Plan:
- Reset, then req_i=001, we=1, addr=0x100, len=3 → gnt_o=001 at cycle 1. sram_addr 0x100,0x104,0x108,0x10C on cycles 1–4. done_o=001 on cycle 4; gnt_o=000 on cycle 5.
- Read req_i=010, addr=0x40, len=1, SRAM preloaded 0xA5A5_0001/0xA5A5_0002 → rvalid_o=010 on cycles 2 and 3 with those values. done_o=010 on cycle 3 (DRAIN).
- req_i=111, all len=0, held → grants 001, 010, 100, 001 in order, each separated by one IDLE cycle.
- addr=0xFFFFFFF8, len=3 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
- Assert reset=0 at beat 2 of a 16-beat write → all outputs 0 asynchronously and no done_o. After release, req_i=100 is granted first only if 0 and 1 are idle; the pointer is back at 0.
- With ARB_LOCK_EN: req_i=011, lock_i=001, requester 0 write len=1 → requester 0 is re-granted back-to-back with no IDLE gap. Then lock_i=000 → the next grant goes to requester 1.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared constants for the SRAM arbiter: default widths, word increment,
// sequencer state encodings and a small index-width helper.
package sram_arb_pkg;

    localparam int DEF_N_REQ  = 3;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_LEN_W  = 4;

    // Byte distance between consecutive beats of a burst
    localparam int WORD_INC = 4;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE  = 2'd0;
    localparam arb_state_t ST_BURST = 2'd1;
    localparam arb_state_t ST_DRAIN = 2'd2;

    // Width of a requester index, never less than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side and SRAM-side signal bundle of the SRAM arbiter.
// The arbiter uses the slave modport; the requesters/SRAM side uses master.
interface sram_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) ();

    logic [N_REQ-1:0]        req_i;
    logic [N_REQ-1:0]        we_i;
    logic [N_REQ*ADDR_W-1:0] addr_i;
    logic [N_REQ*LEN_W-1:0]  len_i;
    logic [N_REQ*DATA_W-1:0] wdata_i;
    logic [N_REQ-1:0]        lock_i;
    logic [N_REQ-1:0]        gnt_o;
    logic [N_REQ-1:0]        beat_o;
    logic [N_REQ-1:0]        rvalid_o;
    logic [DATA_W-1:0]       rdata_o;
    logic [N_REQ-1:0]        done_o;
    logic                    sram_en_o;
    logic                    sram_we_o;
    logic [ADDR_W-1:0]       sram_addr_o;
    logic [DATA_W-1:0]       sram_wdata_o;
    logic [DATA_W-1:0]       sram_rdata_i;

    modport slave (
        input  req_i, we_i, addr_i, len_i, wdata_i, lock_i, sram_rdata_i,
        output gnt_o, beat_o, rvalid_o, rdata_o, done_o,
               sram_en_o, sram_we_o, sram_addr_o, sram_wdata_o
    );

    modport master (
        output req_i, we_i, addr_i, len_i, wdata_i, lock_i, sram_rdata_i,
        input  gnt_o, beat_o, rvalid_o, rdata_o, done_o,
               sram_en_o, sram_we_o, sram_addr_o, sram_wdata_o
    );

endinterface

// File: rtl/sram_arbiter_rr_picker.sv
// Combinational round-robin selector: scans requests starting at the
// pointer, wrapping around, and returns the first one as one-hot + index.
module rr_picker #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_vld
);

    // First request at or after the pointer wins; later hits are masked
    always_comb begin
        o_gnt = {N_REQ{1'b0}};
        o_idx = {IDX_W{1'b0}};
        o_vld = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin : g_scan
            int               w_pos;
            logic [IDX_W-1:0] w_k;
            logic             w_hit;
            w_pos      = (int'(i_ptr) + i) % N_REQ;
            w_k        = IDX_W'(w_pos);
            w_hit      = i_req[w_k] & ~o_vld;
            o_gnt[w_k] = o_gnt[w_k] | w_hit;
            o_idx      = w_hit ? w_k : o_idx;
            o_vld      = o_vld | w_hit;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter and burst sequencer sharing one single-port SRAM
// between N_REQ masters (0 = DMA, 1 = SPI, 2 = I2C).
// Optional grant locking is compiled in with `define ARB_LOCK_EN.
// Outputs decode directly from state registers, so an asynchronous reset
// clears every output immediately.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic          clk,
    input  logic          reset,
    sram_arbiter_if.slave bus_if
);

    localparam int IDX_W = idx_width(N_REQ);

    arb_state_t        r_state;
    logic [N_REQ-1:0]  r_gnt;
    logic [N_REQ-1:0]  r_rvalid;
    logic [N_REQ-1:0]  r_rd_done;
    logic [IDX_W-1:0]  r_gidx;
    logic [IDX_W-1:0]  r_ptr;
    logic [ADDR_W-1:0] r_base;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_beat;
    logic              r_we;

    logic [N_REQ-1:0]  w_pick_oh;
    logic [IDX_W-1:0]  w_pick_idx;
    logic              w_pick_vld;
    logic              w_burst;
    logic              w_last;
    logic              w_relock;
    logic [IDX_W-1:0]  w_sel_idx;
    logic [IDX_W-1:0]  w_ptr_nxt;
    logic [ADDR_W-1:0] w_req_addr;
    logic [LEN_W-1:0]  w_req_len;
    logic              w_req_we;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_req (bus_if.req_i),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_oh),
        .o_idx (w_pick_idx),
        .o_vld (w_pick_vld)
    );

    assign w_burst = (r_state == ST_BURST);
    assign w_last  = (r_beat == r_len);

    // In IDLE the candidate is the picker winner; in BURST it is the grantee
    assign w_sel_idx  = (r_state == ST_IDLE) ? w_pick_idx : r_gidx;
    assign w_req_addr = bus_if.addr_i[w_sel_idx*ADDR_W +: ADDR_W];
    assign w_req_len  = bus_if.len_i[w_sel_idx*LEN_W +: LEN_W];
    assign w_req_we   = bus_if.we_i[w_sel_idx];

    assign w_ptr_nxt = (r_gidx == IDX_W'(N_REQ - 1)) ? {IDX_W{1'b0}}
                     : r_gidx + {{(IDX_W-1){1'b0}}, 1'b1};

`ifdef ARB_LOCK_EN
    assign w_relock = bus_if.lock_i[r_gidx] & bus_if.req_i[r_gidx];
`else
    assign w_relock = 1'b0;
`endif

    // Sequencer: grant selection, burst context, beat counting, read pipeline
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_gnt     <= {N_REQ{1'b0}};
            r_rvalid  <= {N_REQ{1'b0}};
            r_rd_done <= {N_REQ{1'b0}};
            r_gidx    <= {IDX_W{1'b0}};
            r_ptr     <= {IDX_W{1'b0}};
            r_base    <= {ADDR_W{1'b0}};
            r_len     <= {LEN_W{1'b0}};
            r_beat    <= {LEN_W{1'b0}};
            r_we      <= 1'b0;
        end else begin
            // Read data returns one cycle after each read beat
            r_rvalid  <= (w_burst && !r_we) ? r_gnt : {N_REQ{1'b0}};
            r_rd_done <= (w_burst && !r_we && w_last) ? r_gnt : {N_REQ{1'b0}};
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        r_state <= ST_BURST;
                        r_gnt   <= w_pick_oh;
                        r_gidx  <= w_pick_idx;
                        r_base  <= w_req_addr;
                        r_len   <= w_req_len;
                        r_we    <= w_req_we;
                        r_beat  <= {LEN_W{1'b0}};
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BURST: begin
                    if (!w_last) begin
                        r_beat <= r_beat + {{(LEN_W-1){1'b0}}, 1'b1};
                    end else if (w_relock) begin
                        // Locked grantee restarts with fresh context, no gap
                        r_base <= w_req_addr;
                        r_len  <= w_req_len;
                        r_we   <= w_req_we;
                        r_beat <= {LEN_W{1'b0}};
                    end else if (r_we) begin
                        r_state <= ST_IDLE;
                        r_gnt   <= {N_REQ{1'b0}};
                        r_ptr   <= w_ptr_nxt;
                    end else begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= {N_REQ{1'b0}};
                    r_ptr   <= w_ptr_nxt;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= {N_REQ{1'b0}};
                end
            endcase
        end
    end

    assign bus_if.gnt_o        = r_gnt;
    assign bus_if.beat_o       = w_burst ? r_gnt : {N_REQ{1'b0}};
    assign bus_if.done_o       = ((w_burst && r_we && w_last) ? r_gnt : {N_REQ{1'b0}})
                               | r_rd_done;
    assign bus_if.rvalid_o     = r_rvalid;
    assign bus_if.rdata_o      = (|r_rvalid) ? bus_if.sram_rdata_i : {DATA_W{1'b0}};
    assign bus_if.sram_en_o    = w_burst;
    assign bus_if.sram_we_o    = w_burst & r_we;
    assign bus_if.sram_addr_o  = w_burst ? r_base + ADDR_W'(r_beat) * ADDR_W'(WORD_INC)
                               : {ADDR_W{1'b0}};
    assign bus_if.sram_wdata_o = (w_burst && r_we) ? bus_if.wdata_i[r_gidx*DATA_W +: DATA_W]
                               : {DATA_W{1'b0}};

endmodule
